// File: rtl/o_detect_pkg.sv
// Shared types and defaults for the O_detect front end (serializer feeding the detector).
package o_detect_pkg;

   typedef enum logic [1:0] {
      SER_IDLE,
      SER_SHIFT,
      SER_PAR
   } ser_state_t;

   localparam int unsigned SER_W_DEFAULT = 8;

endpackage

// File: rtl/o_detect_serializer.sv
// Parallel-in/serial-out stage driving the O_detect `in` line, one bit per clk.
// Define SER_PARITY_EN to append one even-parity bit after each word.
module o_detect_serializer
   import o_detect_pkg::*;
#(
   parameter int unsigned WIDTH      = SER_W_DEFAULT,
   parameter bit          MSB_FIRST  = 1'b1,
   parameter logic        IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             busy,
   output logic             done
);

   localparam int unsigned     CW           = $clog2(WIDTH);
   localparam logic [CW-1:0]   CNT_LAST     = CW'(WIDTH - 1);
   localparam logic [CW-1:0]   CNT_PRELAST  = CW'(WIDTH - 2);

   ser_state_t       r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sreg;
   logic             r_ser_out;
   logic             r_ser_valid;
   logic             r_done;
`ifdef SER_PARITY_EN
   logic             r_par;
`endif

   logic             w_last_bit;
   logic             w_accept;
   logic             w_load_head;
   logic [WIDTH-1:0] w_load_rest;
   logic             w_sreg_head;
   logic [WIDTH-1:0] w_sreg_rest;

   // sreg holds only the bits not yet on ser_out, aligned so the next bit is always at the head.
   assign w_load_head = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
   assign w_load_rest = MSB_FIRST ? {load_data[WIDTH-2:0], 1'b0} : {1'b0, load_data[WIDTH-1:1]};
   assign w_sreg_head = MSB_FIRST ? r_sreg[WIDTH-1] : r_sreg[0];
   assign w_sreg_rest = MSB_FIRST ? {r_sreg[WIDTH-2:0], 1'b0} : {1'b0, r_sreg[WIDTH-1:1]};

`ifdef SER_PARITY_EN
   assign w_last_bit = (r_state == SER_PAR);
`else
   assign w_last_bit = (r_state == SER_SHIFT) && (r_cnt == CNT_LAST);
`endif

   assign load_ready = (r_state == SER_IDLE) || w_last_bit;
   assign w_accept   = load_valid && load_ready;
   assign ser_out    = r_ser_out;
   assign ser_valid  = r_ser_valid;
   assign busy       = r_ser_valid;
   assign done       = r_done;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= SER_IDLE;
         r_cnt       <= '0;
         r_sreg      <= '0;
         r_ser_out   <= IDLE_LEVEL;
         r_ser_valid <= 1'b0;
         r_done      <= 1'b0;
`ifdef SER_PARITY_EN
         r_par       <= 1'b0;
`endif
      end else if (w_accept) begin
         r_state     <= SER_SHIFT;
         r_cnt       <= '0;
         r_sreg      <= w_load_rest;
         r_ser_out   <= w_load_head;
         r_ser_valid <= 1'b1;
         r_done      <= 1'b0;
`ifdef SER_PARITY_EN
         r_par       <= ^load_data;
`endif
      end else begin
         case (r_state)
            SER_SHIFT: begin
               if (r_cnt == CNT_LAST) begin
`ifdef SER_PARITY_EN
                  r_state   <= SER_PAR;
                  r_ser_out <= r_par;
                  r_done    <= 1'b1;
`else
                  r_state     <= SER_IDLE;
                  r_ser_out   <= IDLE_LEVEL;
                  r_ser_valid <= 1'b0;
                  r_done      <= 1'b0;
`endif
               end else begin
                  r_cnt     <= r_cnt + CW'(1);
                  r_ser_out <= w_sreg_head;
                  r_sreg    <= w_sreg_rest;
`ifdef SER_PARITY_EN
                  r_done    <= 1'b0;
`else
                  r_done    <= (r_cnt == CNT_PRELAST);
`endif
               end
            end
            default: begin
               r_state     <= SER_IDLE;
               r_ser_out   <= IDLE_LEVEL;
               r_ser_valid <= 1'b0;
               r_done      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_o_detect_serializer.sv
// Self-checking bench: one MSB-first and one LSB-first serializer share stimulus,
// compared each cycle against a frame-queue model plus hand-computed literal checks.
module tb_o_detect_serializer;

   localparam int unsigned W = 8;
`ifdef SER_PARITY_EN
   localparam int unsigned FR = W + 1;
`else
   localparam int unsigned FR = W;
`endif

   logic         clk;
   logic         rst;
   logic         load_valid;
   logic [W-1:0] load_data;
   logic         rdy_m, out_m, val_m, busy_m, done_m;
   logic         rdy_l, out_l, val_l, busy_l, done_l;

   int n_chk;
   int n_fail;

   o_detect_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(rdy_m), .load_data(load_data),
      .ser_out(out_m), .ser_valid(val_m), .busy(busy_m), .done(done_m));

   o_detect_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(rdy_l), .load_data(load_data),
      .ser_out(out_l), .ser_valid(val_l), .busy(busy_l), .done(done_l));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Model: every accepted word becomes a list of FR line entries; one entry leaves per clock.
   typedef struct packed {
      bit bm;
      bit bl;
      bit last;
   } ent_t;

   ent_t pend[$];
   ent_t shown;
   bit   shown_v;
   bit   m_rdy;

   assign m_rdy = !shown_v || shown.last;

   function automatic ent_t frame_ent(input logic [W-1:0] w, input int unsigned i);
      ent_t e;
      if (i < W) begin
         e.bm = w[W-1-i];
         e.bl = w[i];
      end else begin
         e.bm = ^w;
         e.bl = ^w;
      end
      e.last = (i == FR - 1);
      return e;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend.delete();
         shown_v = 1'b0;
         shown   = '0;
      end else begin
         if (load_valid && m_rdy)
            for (int unsigned i = 0; i < FR; i++) pend.push_back(frame_ent(load_data, i));
         if (pend.size() > 0) begin
            shown   = pend.pop_front();
            shown_v = 1'b1;
         end else begin
            shown_v = 1'b0;
            shown   = '0;
         end
      end
   end

   always @(negedge clk) begin
      chk("m_ser_out",    {31'd0, out_m},  {31'd0, shown_v ? shown.bm : 1'b0});
      chk("l_ser_out",    {31'd0, out_l},  {31'd0, shown_v ? shown.bl : 1'b0});
      chk("m_ser_valid",  {31'd0, val_m},  {31'd0, shown_v});
      chk("l_ser_valid",  {31'd0, val_l},  {31'd0, shown_v});
      chk("m_busy",       {31'd0, busy_m}, {31'd0, shown_v});
      chk("l_busy",       {31'd0, busy_l}, {31'd0, shown_v});
      chk("m_done",       {31'd0, done_m}, {31'd0, shown_v && shown.last});
      chk("l_done",       {31'd0, done_l}, {31'd0, shown_v && shown.last});
      chk("m_load_ready", {31'd0, rdy_m},  {31'd0, m_rdy});
      chk("l_load_ready", {31'd0, rdy_l},  {31'd0, m_rdy});
   end

   // Send one word and capture its frame; optionally offer 8'hFF mid-word (cycle inj, 0 = none).
   task automatic frame(input logic [W-1:0] w, input int unsigned inj,
                        output logic [FR-1:0] cm, output logic [FR-1:0] cl,
                        output logic [FR-1:0] dv, output logic idle_v);
      cm = '0;
      cl = '0;
      dv = '0;
      load_valid = 1'b1;
      load_data  = w;
      @(negedge clk);
      load_valid = 1'b0;
      for (int unsigned k = 1; k <= FR; k++) begin
         if (k == inj) begin
            load_valid = 1'b1;
            load_data  = 8'hFF;
            chk("inj_ready", {31'd0, rdy_m}, 32'd0);
         end else if (k == inj + 1) begin
            load_valid = 1'b0;
         end
         cm = {cm[FR-2:0], out_m};
         cl = {cl[FR-2:0], out_l};
         dv = {dv[FR-2:0], done_m};
         @(negedge clk);
      end
      load_valid = 1'b0;
      idle_v = val_m;
   endtask

   logic [FR-1:0] cm, cl, dv;
   logic          idle_v;
   logic [FR-1:0] pad;
   int            nv, nd, gap;
   logic [W-1:0]  second;

   initial begin
      n_chk      = 0;
      n_fail     = 0;
      rst        = 1'b0;
      load_valid = 1'b1;
      load_data  = 8'hFF;
      repeat (2) @(negedge clk);
      chk("rst_ser_out",    {31'd0, out_m}, 32'd0);
      chk("rst_ser_valid",  {31'd0, val_m}, 32'd0);
      chk("rst_busy",       {31'd0, busy_m}, 32'd0);
      chk("rst_load_ready", {31'd0, rdy_m}, 32'd1);
      load_valid = 1'b0;
      rst        = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", {31'd0, val_m}, 32'd0);

      // 8'h77: MSB-first 0,1,1,1,0,1,1,1; LSB-first reads back as 8'hEE
      pad = '0;
      pad[0] = 1'b1;
      frame(8'h77, 0, cm, cl, dv, idle_v);
      chk("w77_msb_bits", {24'd0, cm[FR-1 -: 8]}, 32'h77);
      chk("w77_lsb_bits", {24'd0, cl[FR-1 -: 8]}, 32'hEE);
      chk("w77_done_pos", {{(32-FR){1'b0}}, dv}, {{(32-FR){1'b0}}, pad});
      chk("w77_idle_after", {31'd0, idle_v}, 32'd0);
`ifdef SER_PARITY_EN
      chk("w77_parity", {31'd0, cm[0]}, 32'd0);
`endif

      frame(8'hA5, 0, cm, cl, dv, idle_v);
      chk("wA5_lsb_bits", {24'd0, cl[FR-1 -: 8]}, 32'hA5);
      chk("wA5_msb_bits", {24'd0, cm[FR-1 -: 8]}, 32'hA5);

      // back-to-back 8'hF0 then 8'h0F offered on the final bit
      load_valid = 1'b1;
      load_data  = 8'hF0;
      @(negedge clk);
      load_valid = 1'b0;
      nv = 0; nd = 0; gap = 0; second = '0;
      for (int unsigned k = 1; k <= 2 * FR + 1; k++) begin
         if (k == FR) begin
            load_valid = 1'b1;
            load_data  = 8'h0F;
         end else if (k == FR + 1) begin
            load_valid = 1'b0;
         end
         if (val_m) nv++;
         else if (k <= 2 * FR) gap++;
         if (done_m) nd++;
         if (k > FR && k <= FR + W) second = {second[W-2:0], out_m};
         @(negedge clk);
      end
      chk("b2b_valid_bits", nv, 2 * FR);
      chk("b2b_gap", gap, 32'd0);
      chk("b2b_done_count", nd, 32'd2);
      chk("b2b_second_word", {24'd0, second}, 32'h0F);

      // 8'hFF offered during cycle 3 must be ignored
      frame(8'h3C, 3, cm, cl, dv, idle_v);
      chk("busy_ignore_msb", {24'd0, cm[FR-1 -: 8]}, 32'h3C);
      chk("busy_ignore_lsb", {24'd0, cl[FR-1 -: 8]}, 32'h3C);
      chk("busy_ignore_idle", {31'd0, idle_v}, 32'd0);

      // asynchronous abort at bit 4
      load_valid = 1'b1;
      load_data  = 8'h55;
      @(negedge clk);
      load_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("abort_ser_out",    {31'd0, out_m}, 32'd0);
      chk("abort_ser_valid",  {31'd0, val_m}, 32'd0);
      chk("abort_busy",       {31'd0, busy_l}, 32'd0);
      chk("abort_done",       {31'd0, done_m}, 32'd0);
      chk("abort_load_ready", {31'd0, rdy_m}, 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_no_resume", {31'd0, val_m}, 32'd0);

      frame(8'h07, 0, cm, cl, dv, idle_v);
      chk("w07_msb_bits", {24'd0, cm[FR-1 -: 8]}, 32'h07);
      chk("w07_done_pos", {{(32-FR){1'b0}}, dv}, {{(32-FR){1'b0}}, pad});
`ifdef SER_PARITY_EN
      chk("w07_parity", {31'd0, cm[0]}, 32'd1);
`endif

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
